adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture.sv | 155 +++++++++++++++
 tb/tb_adc_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// Serial ADC frame capture: CONV strobe, SCK generation, per-channel
// deserialisation with pad discard, single-shot and continuous triggering.
module adc_capture #(
   parameter int unsigned DATA_W   = 14,
   parameter int unsigned NCH      = 2,
   parameter int unsigned PAD      = 2,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned CONV_W   = 2,
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                    CLK50MHZ,
   input  logic                    RST,
   output logic                    spi_sck,
   output logic                    adc_conv,
   input  logic                    adc_out,
   input  logic                    adc_trig,
   input  logic                    adc_cont,
   input  logic [PERIOD_W-1:0]     adc_period,
   output logic                    adc_busy,
   output logic                    adc_done,
   output logic [NCH*DATA_W-1:0]   adc_data,
   output logic                    adc_ovr,
   input  logic                    adc_ovr_clr
);

   localparam int unsigned SLOT    = PAD + DATA_W;
   localparam int unsigned FRAME   = NCH * SLOT + PAD;
   localparam int unsigned DUR     = CONV_W + 2 * CLK_DIV * FRAME + 1;
   localparam int unsigned FRAME_W = NCH * DATA_W;
   localparam int unsigned SCK_W   = $clog2(FRAME + 1);
   localparam int unsigned POS_W   = $clog2(SLOT);
   localparam int unsigned CH_W    = $clog2(NCH + 1);
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNV_W   = (CONV_W > 1) ? $clog2(CONV_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_DONE} state_t;

   state_t              state;
   logic [DIV_W-1:0]    div_cnt;
   logic [CNV_W-1:0]    conv_cnt;
   logic [SCK_W-1:0]    sck_cnt;
   logic [POS_W-1:0]    pos_cnt;
   logic [CH_W-1:0]     ch_cnt;
   logic [PERIOD_W-1:0] per_cnt;
   logic [DATA_W-1:0]   ch_sh;
   logic [FRAME_W-1:0]  frame_sh;

   logic                per_exp_c;
   logic                start_c;
   logic                ovr_set_c;
   logic [DATA_W-1:0]   word_c;

   // Start decision, overrun detection and the channel word including the bit being sampled
   always_comb begin
      per_exp_c = (per_cnt <= PERIOD_W'(1));
      start_c   = adc_cont ? per_exp_c : adc_trig;
      ovr_set_c = 1'b0;
      if (state != S_IDLE && adc_trig)
         ovr_set_c = 1'b1;
      if (state == S_IDLE && start_c && adc_cont && (32'(adc_period) < DUR))
         ovr_set_c = 1'b1;
      word_c = {ch_sh[DATA_W-2:0], adc_out};
   end

   // Frame sequencer, SCK divider, deserialiser and status flags
   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         spi_sck  <= 1'b0;
         adc_conv <= 1'b0;
         adc_busy <= 1'b0;
         adc_done <= 1'b0;
         adc_ovr  <= 1'b0;
         adc_data <= '0;
         div_cnt  <= '0;
         conv_cnt <= '0;
         sck_cnt  <= '0;
         pos_cnt  <= '0;
         ch_cnt   <= '0;
         per_cnt  <= '0;
         ch_sh    <= '0;
         frame_sh <= '0;
      end else begin
         adc_done <= 1'b0;

         // Period counter runs freely; a frame start below reloads it
         if (per_cnt != '0)
            per_cnt <= per_cnt - PERIOD_W'(1);

         // Sticky overrun, set has priority over clear
         if (ovr_set_c)
            adc_ovr <= 1'b1;
         else if (adc_ovr_clr)
            adc_ovr <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start_c) begin
                  state    <= S_CONV;
                  adc_conv <= 1'b1;
                  adc_busy <= 1'b1;
                  conv_cnt <= '0;
                  per_cnt  <= adc_period;
               end
            end
            S_CONV: begin
               if (conv_cnt == CNV_W'(CONV_W - 1)) begin
                  state    <= S_SHIFT;
                  adc_conv <= 1'b0;
                  div_cnt  <= '0;
                  sck_cnt  <= '0;
                  pos_cnt  <= '0;
                  ch_cnt   <= '0;
               end else begin
                  conv_cnt <= conv_cnt + CNV_W'(1);
               end
            end
            S_SHIFT: begin
               if (sck_cnt == SCK_W'(FRAME)) begin
                  state    <= S_DONE;
                  adc_data <= frame_sh;
                  adc_done <= 1'b1;
               end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                  div_cnt <= '0;
                  spi_sck <= ~spi_sck;
                  if (spi_sck) begin
                     sck_cnt <= sck_cnt + SCK_W'(1);
                  end else begin
                     // Rising SCK: take a data bit unless this is a pad slot
                     if (ch_cnt < CH_W'(NCH) && pos_cnt >= POS_W'(PAD)) begin
                        ch_sh <= word_c;
                        if (pos_cnt == POS_W'(SLOT - 1))
                           frame_sh <= FRAME_W'({word_c, frame_sh} >> DATA_W);
                     end
                     if (pos_cnt == POS_W'(SLOT - 1)) begin
                        pos_cnt <= '0;
                        ch_cnt  <= ch_cnt + CH_W'(1);
                     end else begin
                        pos_cnt <= pos_cnt + POS_W'(1);
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               adc_busy <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: default build (A) and a 4-channel divided-SCK build (B).
module tb_adc_capture;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        sck_a, conv_a, out_a, trig_a, cont_a, busy_a, done_a, ovr_a, clr_a;
   logic [15:0] period_a;
   logic [27:0] data_a;

   logic        sck_b, conv_b, out_b, trig_b, cont_b, busy_b, done_b, ovr_b, clr_b;
   logic [15:0] period_b;
   logic [47:0] data_b;

   adc_capture u_a (
      .CLK50MHZ(clk), .RST(rst_n), .spi_sck(sck_a), .adc_conv(conv_a), .adc_out(out_a),
      .adc_trig(trig_a), .adc_cont(cont_a), .adc_period(period_a), .adc_busy(busy_a),
      .adc_done(done_a), .adc_data(data_a), .adc_ovr(ovr_a), .adc_ovr_clr(clr_a));

   adc_capture #(.DATA_W(12), .NCH(4), .PAD(1), .CLK_DIV(3)) u_b (
      .CLK50MHZ(clk), .RST(rst_n), .spi_sck(sck_b), .adc_conv(conv_b), .adc_out(out_b),
      .adc_trig(trig_b), .adc_cont(cont_b), .adc_period(period_b), .adc_busy(busy_b),
      .adc_done(done_b), .adc_data(data_b), .adc_ovr(ovr_b), .adc_ovr_clr(clr_b));

   // ADC models: bit index counts SCK rising edges since CONV
   logic [13:0] ch_a [2];
   logic        pad_a;
   int          na = 0;
   always @(posedge sck_a or posedge conv_a)
      if (conv_a) na <= 0; else na <= na + 1;
   always_comb begin
      int slot, pos;
      slot = na / 16;
      pos  = na % 16;
      if (slot >= 2 || pos < 2) out_a = pad_a;
      else                      out_a = ch_a[slot][13-(pos-2)];
   end

   logic [11:0] ch_b [4];
   logic        pad_b;
   int          nb = 0;
   always @(posedge sck_b or posedge conv_b)
      if (conv_b) nb <= 0; else nb <= nb + 1;
   always_comb begin
      int slot, pos;
      slot = nb / 13;
      pos  = nb % 13;
      if (slot >= 4 || pos < 1) out_b = pad_b;
      else                      out_b = ch_b[slot][11-(pos-1)];
   end

   int dcnt_a = 0;
   always @(posedge clk) if (done_a) dcnt_a <= dcnt_a + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done_a(output int lat);
      lat = -1;
      for (int n = 1; n <= 1000; n++) begin
         tick();
         if (done_a) begin lat = n; break; end
      end
   endtask

   task automatic wait_idle_a();
      for (int n = 0; n < 400 && busy_a; n++) tick();
   endtask

   task automatic measure_starts_a(input int cycles, output int d1, output int d2);
      int rise [3];
      int nr;
      logic pc;
      rise = '{0, 0, 0};
      nr = 0;
      pc = conv_a;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (conv_a && !pc && nr < 3) begin rise[nr] = c; nr++; end
         pc = conv_a;
      end
      d1 = rise[1] - rise[0];
      d2 = rise[2] - rise[1];
   endtask

   int lat, conv_hi, d0, d1, d2, r1, r2;
   logic ps;

   initial begin
      rst_n = 1'b0;
      trig_a = 0; cont_a = 0; clr_a = 0; period_a = '0;
      trig_b = 0; cont_b = 0; clr_b = 0; period_b = '0;
      ch_a[0] = 14'h2ABC; ch_a[1] = 14'h1234; pad_a = 1'b0;
      ch_b[0] = 12'hA5C; ch_b[1] = 12'h3F0; ch_b[2] = 12'h801; ch_b[3] = 12'h17E; pad_b = 1'b0;
      repeat (3) tick();
      check("rst_sck",  sck_a,  0);
      check("rst_conv", conv_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_ovr",  ovr_a,  0);
      check("rst_data", data_a, 0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", busy_a, 0);

      // Single-shot frame, defaults
      trig_a = 1; tick(); trig_a = 0;
      check("a_busy_start", busy_a, 1);
      conv_hi = conv_a;
      lat = -1;
      for (int n = 1; n <= 400; n++) begin
         tick();
         conv_hi += int'(conv_a);
         if (done_a) begin lat = n; break; end
      end
      check("a_latency", lat, 71);
      check("a_conv_w", conv_hi, 2);
      check("a_sck_cnt", na, 34);
      check("a_data", data_a, {14'h1234, 14'h2ABC});
      tick();
      check("a_done_pulse", done_a, 0);
      check("a_busy_end", busy_a, 0);

      // Trigger during SHIFT: ignored, sets overrun; set beats clear
      d0 = dcnt_a;
      trig_a = 1; tick(); trig_a = 0;
      repeat (30) tick();
      trig_a = 1; tick(); trig_a = 0;
      check("ovr_set", ovr_a, 1);
      clr_a = 1; tick(); clr_a = 0;
      check("ovr_clr", ovr_a, 0);
      trig_a = 1; clr_a = 1; tick(); trig_a = 0; clr_a = 0;
      check("ovr_set_wins", ovr_a, 1);
      wait_idle_a();
      repeat (20) tick();
      check("no_extra_frame", dcnt_a - d0, 1);
      check("idle_after", busy_a, 0);
      clr_a = 1; tick(); clr_a = 0;
      check("ovr_clr2", ovr_a, 0);

      // Pads all ones, data zeros
      pad_a = 1'b1; ch_a[0] = '0; ch_a[1] = '0;
      trig_a = 1; tick(); trig_a = 0;
      wait_done_a(lat);
      check("pad_latency", lat, 71);
      check("pad_data", data_a, 0);
      pad_a = 1'b0; ch_a[0] = 14'h2ABC; ch_a[1] = 14'h1234;
      wait_idle_a();

      // Continuous, period longer than a frame
      period_a = 16'd200; cont_a = 1;
      measure_starts_a(700, d1, d2);
      check("cont200_gap1", d1, 200);
      check("cont200_gap2", d2, 200);
      check("cont200_ovr", ovr_a, 0);
      check("cont200_data", data_a, {14'h1234, 14'h2ABC});
      cont_a = 0;
      wait_idle_a();

      // Continuous, period shorter than a frame: back-to-back
      period_a = 16'd50; cont_a = 1;
      measure_starts_a(400, d1, d2);
      check("cont50_gap1", d1, 73);
      check("cont50_gap2", d2, 73);
      check("cont50_ovr", ovr_a, 1);
      cont_a = 0;
      wait_idle_a();
      clr_a = 1; tick(); clr_a = 0;
      check("cont50_clr", ovr_a, 0);

      // Build B: 4 channels, 12 bits, PAD 1, CLK_DIV 3
      trig_b = 1; tick(); trig_b = 0;
      lat = -1; r1 = -1; r2 = -1; ps = sck_b;
      for (int n = 1; n <= 1000; n++) begin
         tick();
         if (sck_b && !ps) begin
            if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
         end
         ps = sck_b;
         if (done_b) begin lat = n; break; end
      end
      check("b_latency", lat, 321);
      check("b_sck_cnt", nb, 53);
      check("b_sck_period", r2 - r1, 6);
      check("b_ch0", data_b[11:0],  12'hA5C);
      check("b_ch1", data_b[23:12], 12'h3F0);
      check("b_ch2", data_b[35:24], 12'h801);
      check("b_ch3", data_b[47:36], 12'h17E);

      // Reset in the middle of a frame
      trig_a = 1; tick(); trig_a = 0;
      for (int n = 0; n < 200 && na < 20; n++) tick();
      check("mid_sck20", na, 20);
      d0 = dcnt_a;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sck",  sck_a,  0);
      check("mid_rst_conv", conv_a, 0);
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_done", done_a, 0);
      check("mid_rst_data", data_a, 0);
      check("mid_rst_data_b", data_b, 0);
      repeat (5) tick();
      rst_n = 1'b1;
      repeat (100) tick();
      check("mid_no_done", dcnt_a - d0, 0);
      check("mid_data_held", data_a, 0);

      // Continuous mode starts on the first clock after reset release
      rst_n = 1'b0;
      tick();
      cont_a = 1; period_a = 16'd200;
      rst_n = 1'b1;
      tick();
      check("cont_first_conv", conv_a, 1);
      check("cont_first_busy", busy_a, 1);
      cont_a = 0;
      wait_idle_a();
      check("final_idle", busy_a, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1);
   end

endmodule
